// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default stage geometry and the butterfly
// output scaler.
// Optional build macro: BFLY_STAGE_ROUND_EN (round half up when scaling).
package fft_pkg;

    localparam int unsigned FFT_NUM_DEF      = 16;
    localparam int unsigned FFT_IN_WIDTH_DEF = 10;
    localparam int unsigned FFT_HALF_DEF     = 8;

    // Wide working width for the scaler; any sum/diff width fits with headroom,
    // so the +1 rounding term can never overflow.
    localparam int unsigned FFT_CALC_W = 64;

    // Optional divide-by-two of a sign-extended butterfly result.
    function automatic logic signed [FFT_CALC_W-1:0] bfly_scale(
        input logic signed [FFT_CALC_W-1:0] value,
        input logic                         scale
    );
        logic signed [FFT_CALC_W-1:0] res;
        res = value;
        if (scale) begin
`ifdef BFLY_STAGE_ROUND_EN
            res = (value + FFT_CALC_W'(1)) >>> 1;
`else
            res = value >>> 1;
`endif
        end
        return res;
    endfunction

endpackage

// File: rtl/bfly_delay_line.sv
// HALF-deep register file holding one lane vector of complex samples per slot.
// Synchronous write, combinational read; contents need no reset.
module bfly_delay_line #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned NUM    = 16,
    parameter int unsigned HALF   = 8,
    parameter int unsigned ADDR_W = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic signed [WIDTH-1:0] wdata_re [0:NUM-1],
    input  logic signed [WIDTH-1:0] wdata_im [0:NUM-1],
    input  logic [ADDR_W-1:0]       raddr,
    output logic signed [WIDTH-1:0] rdata_re [0:NUM-1],
    output logic signed [WIDTH-1:0] rdata_im [0:NUM-1]
);

    logic signed [WIDTH-1:0] mem_re_q [0:HALF-1][0:NUM-1];
    logic signed [WIDTH-1:0] mem_im_q [0:HALF-1][0:NUM-1];
    logic signed [WIDTH-1:0] mem_re_d [0:HALF-1][0:NUM-1];
    logic signed [WIDTH-1:0] mem_im_d [0:HALF-1][0:NUM-1];

    // Next storage contents: hold, or overwrite the addressed slot.
    always_comb begin
        mem_re_d = mem_re_q;
        mem_im_d = mem_im_q;
        if (we) begin
            for (int l = 0; l < int'(NUM); l++) begin
                mem_re_d[waddr][l] = wdata_re[l];
                mem_im_d[waddr][l] = wdata_im[l];
            end
        end
    end

    // Storage register; deliberately unreset.
    always_ff @(posedge clk) begin
        mem_re_q <= mem_re_d;
        mem_im_q <= mem_im_d;
    end

    // Asynchronous read of the addressed slot.
    always_comb begin
        for (int l = 0; l < int'(NUM); l++) begin
            rdata_re[l] = mem_re_q[raddr][l];
            rdata_im[l] = mem_im_q[raddr][l];
        end
    end

endmodule

// File: rtl/bfly_stage_r2.sv
// Radix-2 DIF butterfly stage: the first half-frame is parked in a delay line,
// each second-half beat emits (a+b) and (a-b) per lane, one cycle later.
// Optional build macro: BFLY_STAGE_ROUND_EN (round half up when scale=1).
module bfly_stage_r2
    import fft_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = FFT_IN_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = IN_WIDTH + 1,
    parameter int unsigned NUM       = FFT_NUM_DEF,
    parameter int unsigned HALF      = FFT_HALF_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  din_i     [0:NUM-1],
    input  logic signed [IN_WIDTH-1:0]  din_q     [0:NUM-1],
    input  logic                        valid_in,
    input  logic                        sof_in,
    input  logic                        scale,
    output logic signed [OUT_WIDTH-1:0] do1_re    [0:NUM-1],
    output logic signed [OUT_WIDTH-1:0] do1_im    [0:NUM-1],
    output logic signed [OUT_WIDTH-1:0] do2_re    [0:NUM-1],
    output logic signed [OUT_WIDTH-1:0] do2_im    [0:NUM-1],
    output logic                        valid_out,
    output logic                        sof_out,
    output logic                        sync_err
);

    localparam int unsigned FRAME = 2 * HALF;
    localparam int unsigned CW    = $clog2(FRAME);
    localparam int unsigned AW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned SW    = IN_WIDTH + 1;

    // Reject geometries that would overflow or leave no delay line.
    if (OUT_WIDTH < IN_WIDTH + 1) begin : g_bad_out_width
        $error("bfly_stage_r2: OUT_WIDTH must be >= IN_WIDTH+1");
    end
    if (HALF < 1) begin : g_bad_half
        $error("bfly_stage_r2: HALF must be >= 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] slot;
    logic          wr_en;
    logic [AW-1:0] waddr, raddr;

    logic signed [IN_WIDTH-1:0] a_re [0:NUM-1];
    logic signed [IN_WIDTH-1:0] a_im [0:NUM-1];

    logic signed [SW-1:0] sum_re [0:NUM-1];
    logic signed [SW-1:0] sum_im [0:NUM-1];
    logic signed [SW-1:0] dif_re [0:NUM-1];
    logic signed [SW-1:0] dif_im [0:NUM-1];

    logic signed [OUT_WIDTH-1:0] add_re [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] add_im [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] sub_re [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] sub_im [0:NUM-1];

    logic signed [OUT_WIDTH-1:0] do1_re_q [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do1_im_q [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do2_re_q [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do2_im_q [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do1_re_d [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do1_im_d [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do2_re_d [0:NUM-1];
    logic signed [OUT_WIDTH-1:0] do2_im_d [0:NUM-1];

    logic valid_out_q, valid_out_d;
    logic sof_out_q, sof_out_d;
    logic sync_err_q, sync_err_d;

    bfly_delay_line #(
        .WIDTH  (IN_WIDTH),
        .NUM    (NUM),
        .HALF   (HALF),
        .ADDR_W (AW)
    ) u_delay (
        .clk      (clk),
        .we       (wr_en),
        .waddr    (waddr),
        .wdata_re (din_i),
        .wdata_im (din_q),
        .raddr    (raddr),
        .rdata_re (a_re),
        .rdata_im (a_im)
    );

    // Full-precision butterfly per lane, then optional scaling to OUT_WIDTH.
    always_comb begin
        for (int l = 0; l < int'(NUM); l++) begin
            sum_re[l] = SW'(a_re[l]) + SW'(din_i[l]);
            sum_im[l] = SW'(a_im[l]) + SW'(din_q[l]);
            dif_re[l] = SW'(a_re[l]) - SW'(din_i[l]);
            dif_im[l] = SW'(a_im[l]) - SW'(din_q[l]);
            add_re[l] = OUT_WIDTH'(bfly_scale(FFT_CALC_W'(sum_re[l]), scale));
            add_im[l] = OUT_WIDTH'(bfly_scale(FFT_CALC_W'(sum_im[l]), scale));
            sub_re[l] = OUT_WIDTH'(bfly_scale(FFT_CALC_W'(dif_re[l]), scale));
            sub_im[l] = OUT_WIDTH'(bfly_scale(FFT_CALC_W'(dif_im[l]), scale));
        end
    end

    // Slot selection, counter advance, delay-line write and output capture.
    always_comb begin
        cnt_d       = cnt_q;
        slot        = cnt_q;
        wr_en       = 1'b0;
        valid_out_d = 1'b0;
        sof_out_d   = 1'b0;
        sync_err_d  = 1'b0;
        do1_re_d    = do1_re_q;
        do1_im_d    = do1_im_q;
        do2_re_d    = do2_re_q;
        do2_im_d    = do2_im_q;

        if (valid_in) begin
            // Frame sync restarts at slot 0; a partial frame is dropped.
            if (sof_in) begin
                slot       = '0;
                sync_err_d = (cnt_q != '0);
            end
            cnt_d = (slot == CW'(FRAME - 1)) ? '0 : slot + CW'(1);
            if (slot < CW'(HALF)) begin
                wr_en = 1'b1;
            end else begin
                valid_out_d = 1'b1;
                sof_out_d   = (slot == CW'(HALF));
                do1_re_d    = add_re;
                do1_im_d    = add_im;
                do2_re_d    = sub_re;
                do2_im_d    = sub_im;
            end
        end

        waddr = AW'(slot);
        raddr = AW'(slot - CW'(HALF));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            valid_out_q <= 1'b0;
            sof_out_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int l = 0; l < int'(NUM); l++) begin
                do1_re_q[l] <= '0;
                do1_im_q[l] <= '0;
                do2_re_q[l] <= '0;
                do2_im_q[l] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            valid_out_q <= valid_out_d;
            sof_out_q   <= sof_out_d;
            sync_err_q  <= sync_err_d;
            do1_re_q    <= do1_re_d;
            do1_im_q    <= do1_im_d;
            do2_re_q    <= do2_re_d;
            do2_im_q    <= do2_im_d;
        end
    end

    assign do1_re    = do1_re_q;
    assign do1_im    = do1_im_q;
    assign do2_re    = do2_re_q;
    assign do2_im    = do2_im_q;
    assign valid_out = valid_out_q;
    assign sof_out   = sof_out_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_bfly_stage_r2.sv
// Directed bench for bfly_stage_r2 with NUM=4, HALF=4, IN_WIDTH=10, OUT_WIDTH=11.
// Honours BFLY_STAGE_ROUND_EN for the scaled-output expectations.
module tb_bfly_stage_r2;

    localparam int unsigned IW = 10;
    localparam int unsigned OW = 11;
    localparam int unsigned N  = 4;
    localparam int unsigned H  = 4;

    typedef int lanes_t [0:N-1];

    logic clk = 1'b0;
    logic rst;
    logic signed [IW-1:0] din_i [0:N-1];
    logic signed [IW-1:0] din_q [0:N-1];
    logic valid_in, sof_in, scale;
    logic signed [OW-1:0] do1_re [0:N-1];
    logic signed [OW-1:0] do1_im [0:N-1];
    logic signed [OW-1:0] do2_re [0:N-1];
    logic signed [OW-1:0] do2_im [0:N-1];
    logic valid_out, sof_out, sync_err;

    int checks = 0;
    int errors = 0;

    bfly_stage_r2 #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .NUM       (N),
        .HALF      (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_i     (din_i),
        .din_q     (din_q),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .scale     (scale),
        .do1_re    (do1_re),
        .do1_im    (do1_im),
        .do2_re    (do2_re),
        .do2_im    (do2_im),
        .valid_out (valid_out),
        .sof_out   (sof_out),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input lanes_t e1re, input lanes_t e2re,
                           input lanes_t e1im, input lanes_t e2im);
        for (int l = 0; l < int'(N); l++) begin
            chk($sformatf("%s_l%0d_do1_re", tag, l), do1_re[l], e1re[l]);
            chk($sformatf("%s_l%0d_do2_re", tag, l), do2_re[l], e2re[l]);
            chk($sformatf("%s_l%0d_do1_im", tag, l), do1_im[l], e1im[l]);
            chk($sformatf("%s_l%0d_do2_im", tag, l), do2_im[l], e2im[l]);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic beat(input logic v, input logic s, input lanes_t re, input lanes_t im);
        valid_in = v;
        sof_in   = s;
        for (int l = 0; l < int'(N); l++) begin
            din_i[l] = IW'(re[l]);
            din_q[l] = IW'(im[l]);
        end
        @(posedge clk);
        #1;
    endtask

    // Frame with beat-dependent data: a_k = (10k+l, -k), b_k = (k, 3k).
    task automatic frame_formula(input logic do_sof, input logic exp_err,
                                 input logic stall, input string tag);
        lanes_t re, im, gre, gim, e1re, e2re, e1im, e2im;
        int pulses;
        pulses = 0;
        gre = '{333, -200, 77, 1};
        gim = '{-311, 5, 250, -9};
        for (int k = 0; k < int'(H); k++) begin
            for (int l = 0; l < int'(N); l++) begin
                re[l] = 10 * k + l;
                im[l] = -k;
            end
            beat(1'b1, do_sof && (k == 0), re, im);
            if (k == 0) chk({tag, "_sync_err_first"}, sync_err, exp_err);
            if (k == 1) chk({tag, "_sync_err_clear"}, sync_err, 0);
            chk($sformatf("%s_a%0d_valid", tag, k), valid_out, 0);
            if (stall) begin
                beat(1'b0, 1'b1, gre, gim);
                chk($sformatf("%s_a%0d_gap_valid", tag, k), valid_out, 0);
            end
        end
        for (int k = 0; k < int'(H); k++) begin
            for (int l = 0; l < int'(N); l++) begin
                re[l]   = k;
                im[l]   = 3 * k;
                e1re[l] = 11 * k + l;
                e2re[l] = 9 * k + l;
                e1im[l] = 2 * k;
                e2im[l] = -4 * k;
            end
            beat(1'b1, 1'b0, re, im);
            if (valid_out === 1'b1) pulses++;
            chk($sformatf("%s_b%0d_sof", tag, k), sof_out, (k == 0) ? 1 : 0);
            chk_out($sformatf("%s_b%0d", tag, k), e1re, e2re, e1im, e2im);
            if (stall) begin
                beat(1'b0, 1'b1, gre, gim);
                if (valid_out === 1'b1) pulses++;
                chk($sformatf("%s_b%0d_hold", tag, k), do1_re[1], 11 * k + 1);
            end
        end
        chk({tag, "_pulses"}, pulses, H);
    endtask

    initial begin
        lanes_t a_re, a_im, b_re, b_im, e1re, e2re, e1im, e2im, zero;
        zero = '{0, 0, 0, 0};
        rst      = 1'b1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        scale    = 1'b0;
        for (int l = 0; l < int'(N); l++) begin
            din_i[l] = '0;
            din_q[l] = '0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        chk("rst_valid", valid_out, 0);
        chk("rst_sof", sof_out, 0);
        chk("rst_sync_err", sync_err, 0);
        chk_out("rst", zero, zero, zero, zero);
        rst = 1'b0;

        // Continuous frame, scale=0, uniform lanes.
        a_re = '{100, 100, 100, 100};
        a_im = '{-5, -5, -5, -5};
        b_re = '{20, 20, 20, 20};
        b_im = '{-5, -5, -5, -5};
        for (int k = 0; k < int'(H); k++) begin
            beat(1'b1, k == 0, a_re, a_im);
            if (k == 0) chk("t1_sync_err", sync_err, 0);
            chk($sformatf("t1_a%0d_valid", k), valid_out, 0);
        end
        for (int k = 0; k < int'(H); k++) begin
            beat(1'b1, 1'b0, b_re, b_im);
            chk($sformatf("t1_b%0d_valid", k), valid_out, 1);
            chk($sformatf("t1_b%0d_sof", k), sof_out, (k == 0) ? 1 : 0);
            chk_out($sformatf("t1_b%0d", k), '{120, 120, 120, 120}, '{80, 80, 80, 80},
                    '{-10, -10, -10, -10}, '{0, 0, 0, 0});
        end

        // Extremes, no sof (counter wraps on its own).
        a_re = '{511, 511, -512, -512};
        a_im = '{-512, -512, 511, 511};
        b_re = '{511, 511, 511, 511};
        b_im = '{511, -512, 511, -512};
        for (int k = 0; k < int'(H); k++) begin
            beat(1'b1, 1'b0, a_re, a_im);
            chk($sformatf("t2_a%0d_valid", k), valid_out, 0);
        end
        for (int k = 0; k < int'(H); k++) begin
            beat(1'b1, 1'b0, b_re, b_im);
            chk($sformatf("t2_b%0d_valid", k), valid_out, 1);
            chk($sformatf("t2_b%0d_sof", k), sof_out, (k == 0) ? 1 : 0);
            chk_out($sformatf("t2_b%0d", k), '{1022, 1022, -1, -1}, '{0, 0, -1023, -1023},
                    '{-1, -1024, 1022, -1}, '{-1023, 0, 0, 1023});
        end

        // Slot ordering, continuous then stalled with sof ignored in the gaps.
        frame_formula(1'b0, 1'b0, 1'b0, "t3_cont");
        frame_formula(1'b1, 1'b0, 1'b1, "t4_stall");

        // Scaled output.
        scale = 1'b1;
        a_re = '{7, -3, 7, -3};
        b_re = '{2, 0, 2, 0};
        a_im = '{-3, 7, -3, 7};
        b_im = '{0, 2, 0, 2};
`ifdef BFLY_STAGE_ROUND_EN
        e1re = '{5, -1, 5, -1};
        e2re = '{3, -1, 3, -1};
        e1im = '{-1, 5, -1, 5};
        e2im = '{-1, 3, -1, 3};
`else
        e1re = '{4, -2, 4, -2};
        e2re = '{2, -2, 2, -2};
        e1im = '{-2, 4, -2, 4};
        e2im = '{-2, 2, -2, 2};
`endif
        for (int k = 0; k < int'(H); k++) begin
            beat(1'b1, k == 0, a_re, a_im);
            if (k == 0) chk("t5_sync_err", sync_err, 0);
        end
        for (int k = 0; k < int'(H); k++) begin
            beat(1'b1, 1'b0, b_re, b_im);
            chk($sformatf("t5_b%0d_valid", k), valid_out, 1);
            chk_out($sformatf("t5_b%0d", k), e1re, e2re, e1im, e2im);
        end
        scale = 1'b0;

        // Resync at cnt=2: aborted frame yields no output, next frame correct.
        beat(1'b1, 1'b1, a_re, a_im);
        chk("t6_pre0_valid", valid_out, 0);
        beat(1'b1, 1'b0, a_re, a_im);
        chk("t6_pre1_valid", valid_out, 0);
        chk("t6_pre1_sync_err", sync_err, 0);
        frame_formula(1'b1, 1'b1, 1'b0, "t6_resync");

        // Reset at cnt=5, then a fresh frame.
        for (int k = 0; k < int'(H); k++) begin
            for (int l = 0; l < int'(N); l++) begin
                a_re[l] = 10 * k + l;
                a_im[l] = -k;
            end
            beat(1'b1, k == 0, a_re, a_im);
        end
        beat(1'b1, 1'b0, '{50, 50, 50, 50}, '{0, 0, 0, 0});
        chk("t7_pre_valid", valid_out, 1);
        chk("t7_pre_do1_re0", do1_re[0], 50);
        rst = 1'b1;
        beat(1'b0, 1'b0, zero, zero);
        rst = 1'b0;
        chk("t7_rst_valid", valid_out, 0);
        chk("t7_rst_sof", sof_out, 0);
        chk("t7_rst_sync_err", sync_err, 0);
        chk_out("t7_rst", zero, zero, zero, zero);
        frame_formula(1'b1, 1'b0, 1'b0, "t7_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfly_stage_r2.md
Name: bfly_stage_r2

Overview:
- Parametrised radix-2 decimation-in-frequency butterfly stage for the block-parallel FFT datapath.
- Accepts NUM complex samples per beat and buffers the first half-frame in an internal delay line.
- On each second-half beat, pairs the stored sample with the incoming one and emits sum and difference.
- Generalises the fixed 16-lane/10-bit stage: width, lanes and depth are parameters; adds stall-tolerant valid, frame sync, per-stage scaling and sync-error reporting.

Parameters:
- IN_WIDTH, 10, signed input component width.
- OUT_WIDTH, IN_WIDTH+1, signed output component width; must be >= IN_WIDTH+1 (elaboration error otherwise).
- NUM, 16, parallel lanes per beat.
- HALF, 8, beats per half-frame; delay-line depth in beats; must be >= 1.
- FRAME, 2*HALF, beats per frame (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- din_i  in  IN_WIDTH x [0:NUM-1]  signed real inputs
- din_q  in  IN_WIDTH x [0:NUM-1]  signed imaginary inputs
- valid_in  in  1  input beat qualifier
- sof_in  in  1  first beat of frame; sampled only with valid_in
- scale  in  1  0: full growth; 1: arithmetic shift right by 1 (quasi-static, change only between frames)
- do1_re, do1_im  out  OUT_WIDTH x [0:NUM-1]  (a+b) outputs
- do2_re, do2_im  out  OUT_WIDTH x [0:NUM-1]  (a-b) outputs
- valid_out  out  1  output beat qualifier
- sof_out  out  1  first output beat of frame
- sync_err  out  1  one-cycle pulse on frame resync

Behaviour:
- Reset: beat counter cnt=0; all outputs 0, including valid_out, sof_out and sync_err. Delay-line contents are don't-care and need no reset.
- cnt (width $clog2(FRAME)) advances only on valid_in beats and wraps FRAME-1 -> 0. Gaps in valid_in freeze all state; no bubbles are inserted.
- Phase A, cnt < HALF: write the lane vector into the delay line at slot cnt. No output is produced.
- Phase B, cnt >= HALF: read slot cnt-HALF as a and take the current input as b, per lane and per component. Full-precision sum = a+b, diff = a-b, each IN_WIDTH+1 bits.
- scale=0: sign-extend sum/diff to OUT_WIDTH.
- scale=1: take sum>>>1 and diff>>>1 (truncation toward -inf), then sign-extend.
- All outputs are registered. Latency is 1 cycle from the phase-B input beat to valid_out.
- valid_out = 1 for exactly one cycle per phase-B beat, i.e. HALF pulses per frame.
- sof_out accompanies the output of the cnt==HALF beat.
- Outputs hold their last value while valid_out = 0.
- Frame sync: valid_in & sof_in forces this beat to slot 0 regardless of cnt, so cnt becomes 1 next cycle.
  - If cnt != 0 at that moment, pulse sync_err for 1 cycle and discard the partial frame.
  - A pending phase-B output already registered still emits.
- valid_in & sof_in with cnt==0: normal operation, no error.
- sof_in without valid_in: ignored.
- Inputs are never back-pressured; the downstream consumer must accept every valid_out.
- Overflow: impossible by construction, since OUT_WIDTH >= IN_WIDTH+1.
- Reset mid-frame clears cnt and outputs in the same edge; the next valid beat is slot 0.

Optional Feature:
- Macro BFLY_STAGE_ROUND_EN.
- Defined: with scale=1, add 1 before the shift (round half up): (x+1)>>>1, computed at IN_WIDTH+2 bits, so the result cannot overflow.
- Undefined: truncating shift only.
- scale=0 output is identical either way.

Decomposition:
- Package fft_pkg: function bfly_scale(value, scale) and localparams for default lane count and widths.
- One sub-module, bfly_delay_line: HALF-deep x NUM-lane complex RAM/register file with write address, read address and enable.
- The stage keeps the counter, control logic and arithmetic.

Test Plan (NUM=4, HALF=4, IN_WIDTH=10, OUT_WIDTH=11):
- Continuous frame, scale=0: beats 0-3 lanes = 100, beats 4-7 lanes = 20 (re), -5 (im). Required: 4 valid_out cycles starting 1 cycle after beat 4, do1_re=120, do2_re=80, do1_im=-10, do2_im=0; sof_out on the first only.
- Extremes, scale=0: a=511, b=511 -> do1=1022, do2=0. a=-512, b=511 -> do1=-1, do2=-1023. No wrap.
- scale=1: a=7, b=2 -> do1=4, do2=2. With BFLY_STAGE_ROUND_EN: do1=5, do2=3. For a=-3, b=0: do1=-2 without the macro, -1 with it.
- Stalls: drop valid_in every other cycle across a frame. Required: outputs bit-identical to the continuous case, with exactly 4 valid_out pulses.
- Resync: sof_in with valid_in at cnt=2. Required: sync_err pulse, no valid_out for the aborted frame, and the following frame correct.
- Reset asserted at cnt=5 for 1 cycle. Required: valid_out=0 and outputs=0 next cycle; the next frame starting with sof_in processes correctly.
